regex_imem_arbiter: RTL
=======================

// Module: regex_imem_arbiter
// PURPOSE
// Round-robin arbiter that shares one single-port instruction memory (BRAM, 1-cycle read latency)
// among N_CPU regex_cpu_pipelined cores. Sits between the cores' memory_valid/addr/ready/data
// fetch ports and the memory. Grants at most one fetch per cycle, fairly, and returns read data
// in the cycle after the core's ready pulse, which is the timing the cores expect.
// PARAMETERS
// N_CPU              4   number of requesting cores (>=2)
// MEMORY_WIDTH       16  instruction word width
// MEMORY_ADDR_WIDTH  11  instruction address width
// PORTS
// clk                 in   1                       clock, all logic on rising edge
// reset               in   1                       synchronous, active-high
// cpu_memory_valid    in   N_CPU                   core i requests a fetch (held until its ready)
// cpu_memory_addr     in   N_CPU*MEMORY_ADDR_WIDTH core i address, slice [i*AW +: AW]
// cpu_memory_ready    out  N_CPU                   one-cycle grant pulse to core i
// cpu_memory_data     out  MEMORY_WIDTH            read-data bus, broadcast to all cores
// mem_ready           in   1                       memory can accept a read this cycle
// mem_en              out  1                       memory read enable
// mem_addr            out  MEMORY_ADDR_WIDTH       memory read address
// mem_rdata           in   MEMORY_WIDTH            memory read data, valid 1 cycle after mem_en
// busy                out  1                       any request pending or read in flight
// BEHAVIOUR
// - Reset values: cpu_memory_ready=0, mem_en=0, mem_addr=0, busy=0; rr_ptr=0, last_grant_mask=0.
// - All outputs except cpu_memory_data and busy are registered. cpu_memory_data = mem_rdata.
// - Eligible set E = cpu_memory_valid & ~last_grant_mask. last_grant_mask is the registered
//   cpu_memory_ready. A core just granted ignores its still-high valid for one cycle.
// - Cycle t: E!=0 and mem_ready=1 -> pick first set bit of E searching from rr_ptr upward,
//   wrapping at N_CPU. At t+1: cpu_memory_ready[g]=1 (only bit set), mem_en=1,
//   mem_addr=addr[g], rr_ptr=(g+1) mod N_CPU.
// - Cycle t+2: mem_rdata valid on cpu_memory_data. Core g samples it; other cores ignore it.
// - Request-to-ready latency: 1 cycle when uncontended. Throughput: 1 grant per cycle to
//   distinct cores. A core is granted at most once in 2 consecutive cycles.
// - mem_ready=0 at t -> no grant at t+1 (ready=0, mem_en=0). rr_ptr, mem_addr hold. Requests wait.
// - Fairness: with K cores continuously requesting, each is granted within K grants.
//   Starvation-free.
// - Valid dropped before grant: request withdrawn. No grant is issued to a non-requesting core.
// - rr_ptr wraps N_CPU-1 -> 0. A single requester at index N_CPU-1 is granted normally.
// - busy = |cpu_memory_valid | mem_en.
// - Reset mid-operation: all state returns to reset values next edge; in-flight read data is
//   discarded (no ready pulse is reissued). Cores are reset alongside.
// - Combinational path from cpu_memory_valid to cpu_memory_ready: none.
// TESTING
// T1 single: reset; core1 valid addr=0x05, mem returns 0xA1B2 -> ready[1] one cycle after
//    valid, mem_en/mem_addr=0x05 same cycle, data 0xA1B2 next cycle.
// T2 contention: cores 0..3 valid together (addr 0x10..0x13), held until own ready -> grants
//    0,1,2,3 on consecutive cycles, each data word matches its addr.
// T3 fairness/wrap: core0 and core3 request continuously, each re-asserting after ready ->
//    grants alternate 0,3,0,3; no core gets two grants in a row.
// T4 stall: 3 cores valid, mem_ready=0 for 5 cycles -> no ready/mem_en. On release, grants
//    resume in rr order.
// T5 withdraw: core2 valid 1 cycle while core0 granted, then low -> core2 never gets ready.
// T6 reset: assert reset the cycle after a grant -> next cycle all outputs 0, rr_ptr=0; a new
//    core2 request is granted 1 cycle later.

Source files
------------

// File: rtl/regex_imem_arbiter.sv
// Round-robin arbiter sharing one single-port instruction memory among N_CPU fetch ports.
// Grants at most one fetch per cycle; read data is broadcast the cycle after the ready pulse.
module regex_imem_arbiter #(
    parameter int unsigned N_CPU             = 4,
    parameter int unsigned MEMORY_WIDTH      = 16,
    parameter int unsigned MEMORY_ADDR_WIDTH = 11
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [N_CPU-1:0]                   cpu_memory_valid,
    input  logic [N_CPU*MEMORY_ADDR_WIDTH-1:0] cpu_memory_addr,
    output logic [N_CPU-1:0]                   cpu_memory_ready,
    output logic [MEMORY_WIDTH-1:0]            cpu_memory_data,
    input  logic                               mem_ready,
    output logic                               mem_en,
    output logic [MEMORY_ADDR_WIDTH-1:0]       mem_addr,
    input  logic [MEMORY_WIDTH-1:0]            mem_rdata,
    output logic                               busy
);

    localparam int unsigned AW    = MEMORY_ADDR_WIDTH;
    localparam int unsigned PTR_W = (N_CPU > 1) ? $clog2(N_CPU) : 1;

    logic [N_CPU-1:0] ready_q, ready_d;
    logic             mem_en_q, mem_en_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [AW-1:0]    addr_arr [N_CPU];
    logic [N_CPU-1:0] elig;
    logic             found;
    logic [PTR_W-1:0] gsel;
    logic [PTR_W-1:0] cand;

    genvar gi;
    generate
        for (gi = 0; gi < N_CPU; gi++) begin : g_addr
            assign addr_arr[gi] = cpu_memory_addr[gi*AW +: AW];
        end
    endgenerate

    // A core granted last cycle still holds valid; mask it so it is not served twice.
    always_comb begin
        elig  = cpu_memory_valid & ~ready_q;
        found = 1'b0;
        gsel  = '0;
        cand  = '0;
        for (int unsigned k = 0; k < N_CPU; k++) begin
            cand = PTR_W'((32'(rr_ptr_q) + k) % N_CPU);
            if (!found && elig[cand]) begin
                found = 1'b1;
                gsel  = cand;
            end
        end
    end

    always_comb begin
        ready_d    = '0;
        mem_en_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        rr_ptr_d   = rr_ptr_q;
        if (mem_ready && found) begin
            ready_d[gsel] = 1'b1;
            mem_en_d      = 1'b1;
            mem_addr_d    = addr_arr[gsel];
            rr_ptr_d      = PTR_W'((32'(gsel) + 32'd1) % N_CPU);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q    <= '0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            ready_q    <= ready_d;
            mem_en_q   <= mem_en_d;
            mem_addr_q <= mem_addr_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign cpu_memory_ready = ready_q;
    assign mem_en           = mem_en_q;
    assign mem_addr         = mem_addr_q;
    assign cpu_memory_data  = mem_rdata;
    assign busy             = (|cpu_memory_valid) | mem_en_q;

endmodule
